// File: rtl/gray_rd_arbiter_pkg.sv
// Shared types and default sizes for the gray-image read arbiter.
package gray_arb_pkg;

    // Arbiter FSM: waiting for a requester, or serving one window burst.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int GRAY_ADDR_W   = 14;
    localparam int GRAY_DATA_W   = 8;
    localparam int LBP_BURST_LEN = 9;

endpackage : gray_arb_pkg

// File: rtl/gray_rd_arbiter_if.sv
// Single read port of the gray-image memory: the arbiter is master, memory is slave.
interface gray_rd_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic              gray_ready;
    logic [DATA_W-1:0] gray_data;

    modport master (output gray_req, output gray_addr, input gray_ready, input gray_data);
    modport slave  (input gray_req, input gray_addr, output gray_ready, output gray_data);
endinterface : gray_rd_arbiter_if

// File: rtl/gray_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: search starts at last_owner+1 and wraps.
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_owner,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;

    // Scan candidates in priority order and keep the first requester found.
    always_comb begin
        any    = 1'b0;
        winner = last_owner;
        sum_s  = {(IDX_W+1){1'b0}};
        cand_s = {IDX_W{1'b0}};
        for (int i = 1; i <= NREQ; i++) begin
            sum_s = {1'b0, last_owner} + (IDX_W+1)'(i);
            if (sum_s >= (IDX_W+1)'(NREQ)) begin
                sum_s = sum_s - (IDX_W+1)'(NREQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDX_W-1:0];
            if (!any && req[cand_s]) begin
                any    = 1'b1;
                winner = cand_s;
            end else begin
                any    = any;
            end
        end
    end

endmodule : rr_pick

// File: rtl/gray_rd_arbiter.sv
// Round-robin burst arbiter sharing the gray-image read port between LBP window engines.
// A grant is held for a whole window burst so neighbourhood fetches never interleave.
module gray_rd_arbiter
    import gray_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int ADDR_W    = GRAY_ADDR_W,
    parameter int DATA_W    = GRAY_DATA_W,
    parameter int BURST_LEN = LBP_BURST_LEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] addr,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        rvalid,
    output logic [DATA_W-1:0]      rdata,
    output logic                   busy,
    gray_rd_arbiter_if.master      mem,
    output logic [NREQ*16-1:0]     grant_cnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       last_owner_q, last_owner_d;
    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [NREQ-1:0]        grant_q, grant_d;
    logic                   busy_q, busy_d;
    logic [NREQ-1:0][15:0]  grant_cnt_q, grant_cnt_d;

    logic                   pick_any_s;
    logic [IDX_W-1:0]       pick_winner_s;
    logic                   owner_req_s;
    logic                   beat_s;
    logic                   full_beat_s;
    logic                   release_s;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .any        (pick_any_s),
        .winner     (pick_winner_s)
    );

    // State register and datapath registers; reset abandons any burst uncounted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            owner_q      <= {IDX_W{1'b0}};
            last_owner_q <= IDX_W'(NREQ - 1);
            beat_cnt_q   <= {CNT_W{1'b0}};
            grant_q      <= {NREQ{1'b0}};
            busy_q       <= 1'b0;
            grant_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            grant_cnt_q  <= grant_cnt_d;
        end
    end

    // Next state: grab a winner when idle, release on full burst or abandon.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        grant_cnt_d  = grant_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (mem.gray_ready && pick_any_s) begin
                    state_d    = ARB_BURST;
                    owner_d    = pick_winner_s;
                    grant_d    = NREQ'(1) << pick_winner_s;
                    beat_cnt_d = {CNT_W{1'b0}};
                    busy_d     = 1'b1;
                end else begin
                    state_d    = ARB_IDLE;
                end
            end
            ARB_BURST: begin
                if (release_s) begin
                    state_d      = ARB_IDLE;
                    last_owner_d = owner_q;
                    grant_d      = {NREQ{1'b0}};
                    busy_d       = 1'b0;
                    beat_cnt_d   = {CNT_W{1'b0}};
                end else if (beat_s) begin
                    beat_cnt_d   = beat_cnt_q + CNT_W'(1);
                end else begin
                    beat_cnt_d   = beat_cnt_q;
                end
                if (full_beat_s) begin
                    grant_cnt_d[owner_q] = grant_cnt_q[owner_q] + 16'd1;
                end else begin
                    grant_cnt_d = grant_cnt_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = {NREQ{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // Outputs: memory strobe/address and beat qualifiers follow the live owner request.
    always_comb begin
        owner_req_s   = req[owner_q];
        beat_s        = 1'b0;
        full_beat_s   = 1'b0;
        release_s     = 1'b0;
        rvalid        = {NREQ{1'b0}};
        mem.gray_req  = 1'b0;
        mem.gray_addr = {ADDR_W{1'b0}};
        case (state_q)
            ARB_BURST: begin
                mem.gray_req  = owner_req_s;
                mem.gray_addr = addr[owner_q*ADDR_W +: ADDR_W];
                beat_s        = owner_req_s && mem.gray_ready;
                full_beat_s   = beat_s && (beat_cnt_q == LAST_BEAT);
                release_s     = full_beat_s || !owner_req_s;
                if (beat_s) begin
                    rvalid = NREQ'(1) << owner_q;
                end else begin
                    rvalid = {NREQ{1'b0}};
                end
            end
            ARB_IDLE: begin
                mem.gray_req  = 1'b0;
                mem.gray_addr = {ADDR_W{1'b0}};
            end
            default: begin
                mem.gray_req  = 1'b0;
                mem.gray_addr = {ADDR_W{1'b0}};
            end
        endcase
    end

    assign rdata     = mem.gray_data;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign grant_cnt = grant_cnt_q;

endmodule : gray_rd_arbiter

// File: doc/gray_rd_arbiter.md
# gray_rd_arbiter

Round-robin read arbiter that shares the single gray-image memory port (`gray_req`/`gray_addr`/`gray_data`/`gray_ready`) between `NREQ` stall-capable LBP window engines. Each grant is held for one window burst of `BURST_LEN` reads, so a 3x3 neighbourhood fetch is never interleaved with another engine's fetch. It sits between the engines and the image memory. Write-side (`lbp_*`) traffic bypasses it.

## Interface
- `NREQ`, default 2: number of requesting engines (2..4).
- `ADDR_W`, default 14: gray address width.
- `DATA_W`, default 8: pixel width.
- `BURST_LEN`, default 9: reads per grant (centre plus 8 neighbours).
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `req`, input, NREQ: per-engine read request; held until served or the burst is abandoned.
- `addr`, input, NREQ*ADDR_W: packed per-engine read addresses; engine k occupies `[k*ADDR_W +: ADDR_W]`.
- `grant`, output, NREQ: one-hot-or-zero burst ownership, registered.
- `rvalid`, output, NREQ: read beat accepted for engine k this cycle.
- `rdata`, output, DATA_W: `gray_data` passed through, broadcast to all engines.
- `busy`, output, 1: a burst is in progress (state is `ARB_BURST`).
- `gray_req`, output, 1: memory read strobe.
- `gray_addr`, output, ADDR_W: memory read address.
- `gray_ready`, input, 1: memory available; reads this cycle are serviced.
- `gray_data`, input, DATA_W: memory read data, valid in the same cycle as `gray_addr`.
- `grant_cnt`, output, NREQ*16: per-engine count of completed full bursts; wraps.

## Operation
- States: `ARB_IDLE`, `ARB_BURST`.
- `ARB_IDLE`:
  - If `gray_ready` is high and any `req` is high, pick the winner by round robin, starting at `last_owner+1` mod NREQ.
  - Register `owner`, set `grant` to one-hot(owner), clear `beat_cnt`, and go to `ARB_BURST`.
  - Otherwise stay in `ARB_IDLE`.
- `ARB_BURST` drive:
  - `gray_req = req[owner]`.
  - `gray_addr = addr[owner]`.
- Beat: a cycle with `req[owner] && gray_ready`. On a beat:
  - `rvalid[owner] = 1`.
  - `beat_cnt` increments.
  - The engine samples `rdata` and advances its address.
- `gray_ready` low: no beat, `beat_cnt` holds, grant is retained.
- Release conditions:
  - A beat with `beat_cnt == BURST_LEN-1` (full burst): increment `grant_cnt[owner]`.
  - `req[owner]` low (abandon): no beat, no count.
- On release, the next cycle the arbiter:
  - sets `last_owner` to `owner`,
  - clears `grant`,
  - enters `ARB_IDLE`.
- `beat_cnt` width is `$clog2(BURST_LEN)`. It never exceeds `BURST_LEN-1`.
- Non-owner engines see `rvalid = 0` and `grant = 0`, and must hold `req` and `addr`.
- Requests from non-owners during a burst are ignored until `ARB_IDLE`. There is no pre-emption.
- Simultaneous requests in `ARB_IDLE`: round-robin order decides. After reset, `last_owner = NREQ-1`, so engine 0 wins first.
- `rdata` is combinational from `gray_data`. Engines qualify it with their own `rvalid`.

## Timing
- Reset values, applied the cycle after `reset` is sampled high, including mid-burst:
  - state `ARB_IDLE`, `grant = 0`, `rvalid = 0`, `busy = 0`, `gray_req = 0`, `gray_addr = 0`.
  - `last_owner = NREQ-1`, all `grant_cnt = 0`.
  - An interrupted burst is not counted.
- Grant latency: `req` first seen in `ARB_IDLE` at cycle t gives `grant` high at t+1. The first beat can occur at t+1.
- Full burst with `gray_ready` always high: beats at t+1..t+BURST_LEN, `grant` drops at t+BURST_LEN+1.
- Handoff bubble: the cycle after release is `ARB_IDLE` with `gray_req = 0`. The next owner's grant appears one cycle later. Back-to-back bursts therefore cost BURST_LEN+1 cycles each.
- Combinational paths:
  - `rvalid`, `gray_req` and `gray_addr` are combinational from registered `owner`/state and live `req`/`addr`/`gray_ready`.
  - `grant` and `busy` are pure registers.
- In `ARB_IDLE`, `gray_addr = 0` and `gray_req = 0`.

## Structure
- Package `gray_arb_pkg` holds:
  - `arb_state_t` enum (`ARB_IDLE`, `ARB_BURST`),
  - `GRAY_ADDR_W = 14`,
  - `GRAY_DATA_W = 8`,
  - `LBP_BURST_LEN = 9`.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req[NREQ]`, `last_owner`.
  - Outputs: `any`, `winner` index.
  - Instantiated once in the arbiter.
- `grant_cnt` registers live in the top-level module.

## Test plan
- Single engine 0, `addr` stepping 0x0081,0x0000..0x0102, `gray_ready` high → `grant = 2'b01` one cycle after `req`; 9 `rvalid[0]` pulses with `rdata` equal to memory at each address; `grant = 0` on the 10th cycle; `grant_cnt[0] = 1`.
- Both engines request in the same cycle after reset → engine 0 bursts first; 1-cycle `ARB_IDLE` bubble; engine 1 then gets 9 beats; `gray_addr` never mixes the two engines within a burst.
- `gray_ready` low for 3 cycles after beat 4 → `beat_cnt` holds at 4, no `rvalid`, `grant` kept; burst finishes after exactly 9 beats, 3 cycles late.
- Engine 1 drops `req` after 5 beats → release with no count, `grant_cnt[1]` unchanged; pending engine 0 is granted 2 cycles later.
- `reset` asserted at beat 6 of a burst → next cycle `grant = 0`, `gray_req = 0`, all `grant_cnt = 0`; the first post-reset grant goes to engine 0.
- Continuous requests from both engines for 10 bursts → grants alternate 0,1,0,1…; each `grant_cnt` = 5; period is 10 cycles per burst.
